// File: rtl/sccb_wr_arbiter_if.sv
// Requester, status and engine-side signals of the shared SCCB write arbiter.
// The arbiter connects through slave; requesters and the engine use master.
interface sccb_wr_arbiter_if;
    logic        req0;
    logic [31:0] data0;
    logic        done0;
    logic        err0;
    logic        req1;
    logic [31:0] data1;
    logic        done1;
    logic        err1;
    logic [31:0] i2c_data;
    logic        i2c_start;
    logic        i2c_tr_end;
    logic        i2c_ack;
    logic        busy;
    logic [1:0]  grant;

    modport master (
        output req0, data0, req1, data1, i2c_tr_end, i2c_ack,
        input  done0, err0, done1, err1, i2c_data, i2c_start, busy, grant
    );

    modport slave (
        input  req0, data0, req1, data1, i2c_tr_end, i2c_ack,
        output done0, err0, done1, err1, i2c_data, i2c_start, busy, grant
    );
endinterface

// File: rtl/sccb_wr_arbiter.sv
// Round-robin arbiter sharing one SCCB write engine between two camera config
// sequencers, with timeout watchdog and a settle gap after OV5640 soft reset.
module sccb_wr_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 2500000,
    parameter int unsigned SETTLE_CYC  = 125000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk_25M,
    input  logic                 camera_rstn,
    sccb_wr_arbiter_if.slave     bus
);

    localparam int unsigned SW    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [21:0] TLAST = 22'(TIMEOUT_CYC - 1);
    localparam logic [SW-1:0] SLAST = SW'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_END,
        WAIT_LOW,
        SETTLE
    } state_t;

    state_t                 state;
    logic                   last_grant;
    logic [21:0]            tcnt;
    logic [SW-1:0]          scnt;
    logic                   nack;
    logic                   tmo;
    logic [SYNC_STAGES-1:0] end_sync;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   end_s;
    logic                   ack_s;
    logic                   is_swrst;
    logic                   low_exit;
    logic                   to_settle;
    logic                   complete;
    logic                   pick0;
    logic                   pick1;

    // Engine-domain handshake inputs cross into clk_25M here
    always_ff @(posedge clk_25M or negedge camera_rstn) begin
        if (!camera_rstn) begin
            end_sync <= '0;
            ack_sync <= '0;
        end else begin
            end_sync[0] <= bus.i2c_tr_end;
            ack_sync[0] <= bus.i2c_ack;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                end_sync[i] <= end_sync[i-1];
                ack_sync[i] <= ack_sync[i-1];
            end
        end
    end

    assign end_s = end_sync[SYNC_STAGES-1];
    assign ack_s = ack_sync[SYNC_STAGES-1];

    always_comb begin
        is_swrst  = (bus.i2c_data[23:8] == 16'h3008) && bus.i2c_data[7];
        // After a timeout the synchronized tr_end is treated as already low
        low_exit  = (state == WAIT_LOW) && (tmo || !end_s);
        to_settle = low_exit && is_swrst && !nack && !tmo;
        complete  = (low_exit && !to_settle) ||
                    ((state == SETTLE) && (scnt == SLAST));
        pick0     = 1'b0;
        pick1     = 1'b0;
        if ((state == IDLE) && !(bus.done0 || bus.done1)) begin
            pick0 = bus.req0 && (!bus.req1 || last_grant);
            pick1 = bus.req1 && !pick0;
        end
    end

    always_ff @(posedge clk_25M or negedge camera_rstn) begin
        if (!camera_rstn) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            tcnt          <= '0;
            scnt          <= '0;
            nack          <= 1'b0;
            tmo           <= 1'b0;
            bus.i2c_data  <= '0;
            bus.i2c_start <= 1'b0;
            bus.grant     <= '0;
            bus.busy      <= 1'b0;
            bus.done0     <= 1'b0;
            bus.done1     <= 1'b0;
            bus.err0      <= 1'b0;
            bus.err1      <= 1'b0;
        end else begin
            bus.done0 <= 1'b0;
            bus.done1 <= 1'b0;
            bus.err0  <= 1'b0;
            bus.err1  <= 1'b0;

            case (state)
                IDLE: begin
                    if (pick0 || pick1) begin
                        bus.i2c_data <= pick0 ? bus.data0 : bus.data1;
                        bus.grant    <= {pick1, pick0};
                        last_grant   <= pick1;
                        bus.busy     <= 1'b1;
                        nack         <= 1'b0;
                        tmo          <= 1'b0;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.i2c_start <= 1'b1;
                    tcnt          <= '0;
                    state         <= WAIT_END;
                end
                WAIT_END: begin
                    if (end_s) begin
                        bus.i2c_start <= 1'b0;
                        nack          <= ack_s;
                        state         <= WAIT_LOW;
                    end else if (tcnt == TLAST) begin
                        bus.i2c_start <= 1'b0;
                        tmo           <= 1'b1;
                        state         <= WAIT_LOW;
                    end else if (tcnt != '1) begin
                        tcnt <= tcnt + 22'd1;
                    end
                end
                WAIT_LOW: begin
                    if (to_settle) begin
                        scnt  <= '0;
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    scnt <= scnt + SW'(1);
                end
                default: state <= IDLE;
            endcase

            // Completion status is registered so it appears in the first IDLE cycle
            if (complete) begin
                state     <= IDLE;
                bus.busy  <= 1'b0;
                bus.grant <= '0;
                bus.done0 <= bus.grant[0];
                bus.done1 <= bus.grant[1];
                bus.err0  <= bus.grant[0] && (nack || tmo);
                bus.err1  <= bus.grant[1] && (nack || tmo);
            end
        end
    end

endmodule

// File: tb/tb_sccb_wr_arbiter.sv
// Self-checking bench for sccb_wr_arbiter: directed vector table, reset
// sequence and randomized transactions against a transaction-level model.
module tb_sccb_wr_arbiter;

    localparam int unsigned TO_CYC = 1000;
    localparam int unsigned ST_CYC = 200;
    localparam int unsigned SYNC   = 2;
    // tr_end fall to done: synchronizer depth plus one FSM cycle
    localparam int unsigned END_LAT = SYNC + 1;

    logic clk_25M;
    logic camera_rstn;
    int   checks;
    int   errors;

    sccb_wr_arbiter_if bus ();

    sccb_wr_arbiter #(
        .TIMEOUT_CYC (TO_CYC),
        .SETTLE_CYC  (ST_CYC),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk_25M     (clk_25M),
        .camera_rstn (camera_rstn),
        .bus         (bus)
    );

    initial clk_25M = 1'b0;
    always #20 clk_25M = ~clk_25M;

    typedef struct {
        logic        r0;
        logic        r1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        ack;
        logic        to;
        logic [1:0]  eg;
        logic [31:0] ed;
        logic        ee;
        logic        es;
    } vec_t;

    vec_t tbl [10];
    logic m_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        bus.req0  = v.r0;
        bus.req1  = v.r1;
        bus.data0 = v.d0;
        bus.data1 = v.d1;
    endtask

    task automatic run_txn(input vec_t v, input bit perturb);
        int n;
        int hold;
        bit moved;
        n = 0;
        while (bus.grant == 2'b00 && n < 20) begin
            @(negedge clk_25M);
            n++;
        end
        chk("grant", {30'd0, bus.grant}, {30'd0, v.eg});
        if (bus.grant == 2'b00) return;
        chk("i2c_data", bus.i2c_data, v.ed);
        chk("grant_state", {29'd0, bus.busy, bus.i2c_start, bus.done0 | bus.done1}, 32'd4);
        if (perturb) begin
            bus.data0 = $urandom;
            bus.data1 = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                if (v.eg[0]) bus.req0 = 1'b0;
                else         bus.req1 = 1'b0;
            end
        end
        @(negedge clk_25M);
        chk("start_rise", {31'd0, bus.i2c_start}, 32'd1);
        if (v.to) begin
            n = 1;
            @(negedge clk_25M);
            while (bus.i2c_start && n < int'(TO_CYC) + 100) begin
                n++;
                @(negedge clk_25M);
            end
            chk("start_len", n, TO_CYC);
            @(negedge clk_25M);
        end else begin
            repeat ($urandom_range(0, 4)) @(negedge clk_25M);
            bus.i2c_tr_end = 1'b1;
            bus.i2c_ack    = v.ack;
            hold = $urandom_range(1, 4);
            repeat (hold) @(negedge clk_25M);
            bus.i2c_tr_end = 1'b0;
            bus.i2c_ack    = 1'b0;
            n = 0;
            moved = 1'b0;
            do begin
                @(negedge clk_25M);
                n++;
                if (bus.busy && bus.grant != v.eg) moved = 1'b1;
            end while (bus.busy && n < int'(ST_CYC) + 50);
            chk("busy_len", n, END_LAT + (v.es ? ST_CYC : 0));
            chk("grant_held", {31'd0, moved}, 32'd0);
        end
        chk("done", {30'd0, bus.done1, bus.done0}, {30'd0, v.eg});
        chk("err", {30'd0, bus.err1, bus.err0}, v.ee ? {30'd0, v.eg} : 32'd0);
        chk("idle", {28'd0, bus.busy, bus.i2c_start, bus.grant}, 32'd0);
    endtask

    function automatic vec_t mk(input logic r0, input logic r1, input logic [31:0] d0,
                                input logic [31:0] d1, input logic ack, input logic to);
        vec_t v;
        v.r0  = r0;
        v.r1  = r1;
        v.d0  = d0;
        v.d1  = d1;
        v.ack = ack & ~to;
        v.to  = to;
        // Round robin: a lone request wins; on a tie the one not served last wins
        if (r0 && r1) v.eg = m_last ? 2'b01 : 2'b10;
        else          v.eg = r0 ? 2'b01 : 2'b10;
        m_last = v.eg[1];
        v.ed = v.eg[0] ? d0 : d1;
        v.ee = v.ack | to;
        v.es = !v.ee && (v.ed[23:8] == 16'h3008) && v.ed[7];
        return v;
    endfunction

    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 2) == 0) w = {8'h78, 16'h3008, 8'($urandom)};
        return w;
    endfunction

    initial begin
        #(40 * 200000);
        $display("FAIL watchdog simulation time limit");
        $fatal(1);
    end

    initial begin
        vec_t v;
        checks = 0;
        errors = 0;
        //            r0    r1    d0            d1            ack   to    eg     ed            ee    es
        tbl[0] = '{1'b1, 1'b0, 32'h78310311, 32'h00000000, 1'b0, 1'b0, 2'b01, 32'h78310311, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 32'h78300A01, 32'h78310312, 1'b0, 1'b0, 2'b10, 32'h78310312, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 32'h78300A02, 32'h78310313, 1'b0, 1'b0, 2'b01, 32'h78300A02, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 32'h78300A03, 32'h78310314, 1'b1, 1'b0, 2'b10, 32'h78310314, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 32'h00000000, 32'h78310315, 1'b0, 1'b0, 2'b10, 32'h78310315, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 32'h78300882, 32'h78380411, 1'b0, 1'b0, 2'b01, 32'h78300882, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 32'h78301234, 32'h78300842, 1'b0, 1'b0, 2'b10, 32'h78300842, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 32'h78310316, 32'h00000000, 1'b0, 1'b1, 2'b01, 32'h78310316, 1'b1, 1'b0};
        tbl[8] = '{1'b1, 1'b0, 32'h78300882, 32'h00000000, 1'b1, 1'b0, 2'b01, 32'h78300882, 1'b1, 1'b0};
        tbl[9] = '{1'b0, 1'b1, 32'h00000000, 32'h78300882, 1'b0, 1'b1, 2'b10, 32'h78300882, 1'b1, 1'b0};

        camera_rstn    = 1'b0;
        bus.req0       = 1'b0;
        bus.req1       = 1'b0;
        bus.data0      = '0;
        bus.data1      = '0;
        bus.i2c_tr_end = 1'b0;
        bus.i2c_ack    = 1'b0;
        repeat (3) @(negedge clk_25M);
        chk("rst_ctrl", {24'd0, bus.done0, bus.err0, bus.done1, bus.err1,
                         bus.i2c_start, bus.busy, bus.grant}, 32'd0);
        chk("rst_data", bus.i2c_data, 32'd0);
        camera_rstn = 1'b1;
        @(negedge clk_25M);

        for (int i = 0; i < 10; i++) begin
            apply(tbl[i]);
            run_txn(tbl[i], 1'b0);
        end
        m_last = 1'b1;

        // Reset while requester 1 owns the bus; requester 0 must win afterwards
        v = mk(1'b1, 1'b0, 32'h78310320, 32'h0, 1'b0, 1'b0);
        apply(v);
        run_txn(v, 1'b0);
        bus.req0  = 1'b1;
        bus.req1  = 1'b1;
        bus.data0 = 32'h78310321;
        bus.data1 = 32'h78310322;
        repeat (2) @(negedge clk_25M);
        chk("pre_rst_grant", {30'd0, bus.grant}, 32'd2);
        repeat (3) @(negedge clk_25M);
        chk("pre_rst_start", {31'd0, bus.i2c_start}, 32'd1);
        #5 camera_rstn = 1'b0;
        #1;
        chk("rst_mid", {28'd0, bus.i2c_start, bus.busy, bus.done0 | bus.done1,
                        |bus.grant}, 32'd0);
        @(negedge clk_25M);
        camera_rstn = 1'b1;
        m_last = 1'b1;
        v = mk(1'b1, 1'b1, 32'h78310321, 32'h78310322, 1'b0, 1'b0);
        run_txn(v, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0] r;
            r = 2'($urandom_range(1, 3));
            v = mk(r[0], r[1], rnd_word(), rnd_word(),
                   $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
            apply(v);
            run_txn(v, 1'b1);
        end

        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(negedge clk_25M);
        chk("final_done_clr", {30'd0, bus.done1, bus.done0}, 32'd0);
        repeat (3) @(negedge clk_25M);
        chk("final_idle", {30'd0, bus.busy, |bus.grant}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
